// File: rtl/pll_reconfig_pkg.sv
// rtl/pll_reconfig_pkg.sv - PLL reconfiguration field map, bank layout, reset values and FSM encoding
package pll_reconfig_pkg;

  localparam int SCAN_LEN = 50;

  localparam logic [3:0] TYPE_N    = 4'd0;
  localparam logic [3:0] TYPE_M    = 4'd1;
  localparam logic [3:0] TYPE_CPLF = 4'd2;
  localparam logic [3:0] TYPE_C0   = 4'd4;

  localparam logic [2:0] P_N       = 3'd0;
  localparam logic [2:0] P_NBYP    = 3'd4;
  localparam logic [2:0] P_M       = 3'd0;
  localparam logic [2:0] P_CP      = 3'd0;
  localparam logic [2:0] P_LFR     = 3'd1;
  localparam logic [2:0] P_LFC     = 3'd2;
  localparam logic [2:0] P_C0HI    = 3'd0;
  localparam logic [2:0] P_C0LO    = 3'd1;
  localparam logic [2:0] P_C0CTRL  = 3'd2;
  localparam logic [2:0] P_C0ODD   = 3'd5;

  localparam int W_N = 9, W_M = 9, W_CP = 4, W_LFR = 6, W_LFC = 2;
  localparam int W_C0 = 8, W_C0CTRL = 2;

  typedef struct packed {
    logic [W_N-1:0]      n;
    logic                n_byp;
    logic [W_M-1:0]      m;
    logic [W_CP-1:0]     cp;
    logic [W_LFR-1:0]    lf_r;
    logic [W_LFC-1:0]    lf_c;
    logic [W_C0-1:0]     c0_hi;
    logic [W_C0-1:0]     c0_lo;
    logic [W_C0CTRL-1:0] c0_ctrl;
    logic                c0_odd;
  } pll_bank_t;

  localparam pll_bank_t BANK_RESET = '{n: 9'd1, n_byp: 1'b1, m: 9'd12, cp: 4'd0,
                                       lf_r: 6'd0, lf_c: 2'd0, c0_hi: 8'd5, c0_lo: 8'd5,
                                       c0_ctrl: 2'd0, c0_odd: 1'b0};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_RD     = 3'd1,
    ST_LOAD      = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_UPDATE    = 3'd4,
    ST_WAIT_DONE = 3'd5
  } state_t;

  // Scan chain order, MSB leaves first.
  function automatic logic [SCAN_LEN-1:0] scan_word(input pll_bank_t b);
    return {b.lf_c, b.lf_r, b.cp, b.n, b.n_byp, b.m, b.c0_hi, b.c0_lo, b.c0_odd, b.c0_ctrl};
  endfunction

endpackage

// File: rtl/pll_scan_shifter.sv
// rtl/pll_scan_shifter.sv - serialises a loaded word onto scanclk/scandata, pulses done after the last bit
module pll_scan_shifter
  import pll_reconfig_pkg::*;
#(
  parameter int SCAN_DIV = 2
) (
  input  logic                clk,
  input  logic                nRST,
  input  logic                load,
  input  logic [SCAN_LEN-1:0] word,
  output logic                scanclk,
  output logic                scanclkena,
  output logic                scandata,
  output logic                done
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SCAN_LEN-1:0] sreg;
  logic [DW-1:0]       div;
  logic [5:0]          bits;

  assign scandata = sreg[SCAN_LEN-1];

  // Data only moves on the scanclk falling toggle; the last falling toggle ends the scan.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      sreg       <= '0;
      div        <= '0;
      bits       <= '0;
      scanclk    <= 1'b0;
      scanclkena <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        sreg       <= word;
        div        <= '0;
        bits       <= '0;
        scanclk    <= 1'b0;
        scanclkena <= 1'b1;
      end else if (scanclkena) begin
        if (div == DW'(SCAN_DIV - 1)) begin
          div <= '0;
          if (!scanclk) begin
            scanclk <= 1'b1;
            if (bits != 6'(SCAN_LEN)) bits <= bits + 6'd1;
          end else if (bits == 6'(SCAN_LEN)) begin
            scanclk    <= 1'b0;
            scanclkena <= 1'b0;
            sreg       <= '0;
            done       <= 1'b1;
          end else begin
            scanclk <= 1'b0;
            sreg    <= {sreg[SCAN_LEN-2:0], 1'b0};
          end
        end else begin
          div <= div + DW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pll_reconfig_responder.sv
// rtl/pll_reconfig_responder.sv - PLL reconfig parameter responder: shadow bank, scan, update, scandone wait
// Optional read path enabled by defining PLL_PARAM_READ_EN.
module pll_reconfig_responder
  import pll_reconfig_pkg::*;
#(
  parameter int SCAN_DIV     = 2,
  parameter int WR_BUSY      = 2,
  parameter int DONE_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       Wr_param,
  input  logic       Rd_param,
  input  logic       Reconfig,
  input  logic [3:0] Count_type,
  input  logic [2:0] Count_param,
  input  logic [8:0] Data_in,
  output logic       busy,
  output logic [8:0] data_out,
  output logic       timeout_err,
  output logic       scanclk,
  output logic       scanclkena,
  output logic       scandata,
  output logic       configupdate,
  input  logic       scandone
);

  localparam int WBW = (WR_BUSY > 1) ? $clog2(WR_BUSY) : 1;

  state_t         state, state_n;
  pll_bank_t      bank;
  logic [WBW-1:0] wcnt, wcnt_n;
  logic [9:0]     tcnt, tcnt_n;
  logic           idle, acc_cfg, acc_wr, acc_rd, scan_load, scan_done, to_hit;

  assign idle    = (state == ST_IDLE);
  assign acc_cfg = idle && Reconfig;
  assign acc_wr  = idle && !Reconfig && Wr_param;

`ifdef PLL_PARAM_READ_EN
  logic [8:0] rd_val;
  assign acc_rd = idle && !Reconfig && !Wr_param && Rd_param;

  always_comb begin
    rd_val = '0;
    case (Count_type)
      TYPE_N: begin
        if (Count_param == P_N)    rd_val = bank.n;
        if (Count_param == P_NBYP) rd_val = 9'(bank.n_byp);
      end
      TYPE_M:    if (Count_param == P_M) rd_val = bank.m;
      TYPE_CPLF: begin
        if (Count_param == P_CP)  rd_val = 9'(bank.cp);
        if (Count_param == P_LFR) rd_val = 9'(bank.lf_r);
        if (Count_param == P_LFC) rd_val = 9'(bank.lf_c);
      end
      TYPE_C0: begin
        if (Count_param == P_C0HI)   rd_val = 9'(bank.c0_hi);
        if (Count_param == P_C0LO)   rd_val = 9'(bank.c0_lo);
        if (Count_param == P_C0CTRL) rd_val = 9'(bank.c0_ctrl);
        if (Count_param == P_C0ODD)  rd_val = 9'(bank.c0_odd);
      end
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST)       data_out <= '0;
    else if (acc_rd) data_out <= rd_val;
  end
`else
  logic unused_rd;
  assign unused_rd = Rd_param;
  assign acc_rd    = 1'b0;
  assign data_out  = '0;
`endif

  // Writes are only taken in IDLE, so the bank is frozen for the whole scan.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      bank <= BANK_RESET;
    end else if (acc_wr) begin
      case (Count_type)
        TYPE_N: begin
          if (Count_param == P_N)    bank.n     <= Data_in;
          if (Count_param == P_NBYP) bank.n_byp <= Data_in[0];
        end
        TYPE_M:    if (Count_param == P_M) bank.m <= Data_in;
        TYPE_CPLF: begin
          if (Count_param == P_CP)  bank.cp   <= Data_in[W_CP-1:0];
          if (Count_param == P_LFR) bank.lf_r <= Data_in[W_LFR-1:0];
          if (Count_param == P_LFC) bank.lf_c <= Data_in[W_LFC-1:0];
        end
        TYPE_C0: begin
          if (Count_param == P_C0HI)   bank.c0_hi   <= Data_in[W_C0-1:0];
          if (Count_param == P_C0LO)   bank.c0_lo   <= Data_in[W_C0-1:0];
          if (Count_param == P_C0CTRL) bank.c0_ctrl <= Data_in[W_C0CTRL-1:0];
          if (Count_param == P_C0ODD)  bank.c0_odd  <= Data_in[0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= ST_IDLE;
      wcnt  <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      tcnt  <= tcnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    wcnt_n    = wcnt;
    tcnt_n    = tcnt;
    scan_load = 1'b0;
    to_hit    = 1'b0;
    case (state)
      ST_IDLE: begin
        wcnt_n = '0;
        tcnt_n = '0;
        if (acc_cfg)               state_n = ST_LOAD;
        else if (acc_wr || acc_rd) state_n = ST_WR_RD;
      end
      ST_WR_RD: begin
        if (wcnt == WBW'(WR_BUSY - 1)) state_n = ST_IDLE;
        else                           wcnt_n  = wcnt + WBW'(1);
      end
      ST_LOAD: begin
        scan_load = 1'b1;
        state_n   = ST_SHIFT;
      end
      ST_SHIFT:  if (scan_done) state_n = ST_UPDATE;
      ST_UPDATE: state_n = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (scandone) begin
          state_n = ST_IDLE;
        end else begin
          tcnt_n = (tcnt == '1) ? tcnt : tcnt + 10'd1;
          if (tcnt_n == 10'(DONE_TIMEOUT)) begin
            to_hit  = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST)        timeout_err <= 1'b0;
    else if (acc_cfg) timeout_err <= 1'b0;
    else if (to_hit)  timeout_err <= 1'b1;
  end

  assign busy         = !idle;
  assign configupdate = (state == ST_UPDATE);

  pll_scan_shifter #(.SCAN_DIV(SCAN_DIV)) u_shifter (
    .clk        (clk),
    .nRST       (nRST),
    .load       (scan_load),
    .word       (scan_word(bank)),
    .scanclk    (scanclk),
    .scanclkena (scanclkena),
    .scandata   (scandata),
    .done       (scan_done)
  );

endmodule

// File: tb/tb_pll_reconfig_responder.sv
// tb/tb_pll_reconfig_responder.sv - self-checking bench: vector table, scan capture, random ops vs field-map model
module tb_pll_reconfig_responder;

  localparam int SCAN_DIV = 2, WR_BUSY = 2, DONE_TIMEOUT = 16, LEN = 50;
`ifdef PLL_PARAM_READ_EN
  localparam bit RD_EN = 1'b1;
`else
  localparam bit RD_EN = 1'b0;
`endif

  logic clk = 1'b0, nRST = 1'b0;
  logic Wr_param = 1'b0, Rd_param = 1'b0, Reconfig = 1'b0, scandone = 1'b0;
  logic [3:0] Count_type = '0;
  logic [2:0] Count_param = '0;
  logic [8:0] Data_in = '0;
  logic busy, timeout_err, scanclk, scanclkena, scandata, configupdate;
  logic [8:0] data_out;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  pll_reconfig_responder #(.SCAN_DIV(SCAN_DIV), .WR_BUSY(WR_BUSY), .DONE_TIMEOUT(DONE_TIMEOUT)) dut (
    .clk(clk), .nRST(nRST), .Wr_param(Wr_param), .Rd_param(Rd_param), .Reconfig(Reconfig),
    .Count_type(Count_type), .Count_param(Count_param), .Data_in(Data_in), .busy(busy),
    .data_out(data_out), .timeout_err(timeout_err), .scanclk(scanclk), .scanclkena(scanclkena),
    .scandata(scandata), .configupdate(configupdate), .scandone(scandone));

  // Reference model: field address = type*8 + param.
  int fwidth[int];
  int fval[int];
  int chain[10] = '{18, 17, 16, 0, 4, 8, 32, 33, 37, 34};
  logic [8:0] dout_model;

  function automatic void model_reset();
    fwidth.delete(); fval.delete();
    fwidth[0] = 9;  fval[0] = 1;   fwidth[4] = 1;  fval[4] = 1;
    fwidth[8] = 9;  fval[8] = 12;
    fwidth[16] = 4; fval[16] = 0;  fwidth[17] = 6; fval[17] = 0;  fwidth[18] = 2; fval[18] = 0;
    fwidth[32] = 8; fval[32] = 5;  fwidth[33] = 8; fval[33] = 5;
    fwidth[34] = 2; fval[34] = 0;  fwidth[37] = 1; fval[37] = 0;
  endfunction

  function automatic void model_write(int t, int p, int d);
    int a;
    a = t * 8 + p;
    if (fwidth.exists(a)) fval[a] = d & ((1 << fwidth[a]) - 1);
  endfunction

  function automatic int model_read(int t, int p);
    int a;
    a = t * 8 + p;
    return fwidth.exists(a) ? fval[a] : 0;
  endfunction

  function automatic logic [49:0] expected_word();
    logic [49:0] w;
    w = '0;
    foreach (chain[i])
      for (int b = fwidth[chain[i]] - 1; b >= 0; b--)
        w = {w[48:0], ((fval[chain[i]] >> b) & 1) != 0};
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic strobe(input bit wr, input bit rd, input bit cfg,
                        input logic [3:0] t, input logic [2:0] p, input logic [8:0] d);
    Wr_param = wr; Rd_param = rd; Reconfig = cfg;
    Count_type = t; Count_param = p; Data_in = d;
    @(negedge clk);
    Wr_param = 1'b0; Rd_param = 1'b0; Reconfig = 1'b0;
  endtask

  task automatic do_op(input bit wr, input bit rd, input logic [3:0] t, input logic [2:0] p,
                       input logic [8:0] d, input logic [8:0] exp_rd, input string tag);
    int n;
    bit acc;
    acc = wr || (rd && RD_EN);
    if (wr) model_write(int'(t), int'(p), int'(d));
    else if (rd && RD_EN) dout_model = exp_rd;
    strobe(wr, rd, 1'b0, t, p, d);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_len"}, n, acc ? WR_BUSY : 0);
    check({tag, "_data_out"}, data_out, dout_model);
  endtask

  logic [49:0] cap_word;
  int rises, cu_cnt, done_lag, to_lag, edge_err, per_err;
  logic te_first;
  bit scan_ok;

  task automatic run_scan(input int done_delay, input bit with_wr, input bit wr_mid);
    int since_cu, since_done, since_rise;
    bit pclk, pena, pdata, cu_seen, sd_set, mid_done;
    cap_word = '0; rises = 0; cu_cnt = 0; done_lag = -1; to_lag = -1;
    edge_err = 0; per_err = 0; scan_ok = 0;
    since_cu = 0; since_done = 0; since_rise = -1;
    pclk = 0; pena = 0; pdata = 0; cu_seen = 0; sd_set = 0; mid_done = 0;
    strobe(with_wr, 1'b0, 1'b1, 4'd1, 3'd0, 9'd77);
    te_first = timeout_err;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (since_rise >= 0) since_rise++;
      if (scanclk && !pclk) begin
        cap_word = {cap_word[48:0], scandata};
        rises++;
        if (since_rise > 0 && since_rise != 2 * SCAN_DIV) per_err++;
        since_rise = 0;
      end
      if (scanclkena && pena && scandata !== pdata && !(pclk && !scanclk)) edge_err++;
      if (sd_set) since_done++;
      if (cu_seen) since_cu++;
      if (configupdate) begin cu_cnt++; cu_seen = 1; since_cu = 0; end
      if (busy !== 1'b1) begin
        done_lag = sd_set ? since_done : -1;
        to_lag = since_cu;
        scan_ok = 1;
        break;
      end
      Wr_param = 1'b0;
      if (wr_mid && rises == 10 && !mid_done) begin
        Wr_param = 1'b1; Count_type = 4'd1; Count_param = 3'd0; Data_in = 9'd99; mid_done = 1;
      end
      if (cu_seen && done_delay > 0 && !sd_set && since_cu >= done_delay) begin
        scandone = 1'b1; sd_set = 1; since_done = 0;
      end
      pclk = scanclk; pena = scanclkena; pdata = scandata;
      @(negedge clk);
    end
    scandone = 1'b0;
    Wr_param = 1'b0;
  endtask

  task automatic scan_checks(input string tag, input bit exp_to);
    check({tag, "_bounded"}, scan_ok, 1);
    check({tag, "_rises"}, rises, LEN);
    check({tag, "_word"}, cap_word, expected_word());
    check({tag, "_cfgupd_pulses"}, cu_cnt, 1);
    check({tag, "_data_edge"}, edge_err, 0);
    check({tag, "_scanclk_period"}, per_err, 0);
    check({tag, "_scan_idle"}, {scanclk, scanclkena}, 0);
    check({tag, "_te_cleared"}, te_first, 0);
    if (exp_to) begin
      check({tag, "_to_lag"}, to_lag, DONE_TIMEOUT + 1);
      check({tag, "_timeout_err"}, timeout_err, 1);
    end else begin
      check({tag, "_done_lag"}, done_lag, 1);
      check({tag, "_timeout_err"}, timeout_err, 0);
    end
  endtask

  typedef struct {
    bit wr; bit rd; logic [3:0] t; logic [2:0] p; logic [8:0] d; logic [8:0] exp;
  } vec_t;
  vec_t vt[14];

  initial begin
    int r;
    bit pc;
    vt[0]  = '{1, 0, 4'd1, 3'd0, 9'd20,   9'd0};
    vt[1]  = '{0, 1, 4'd1, 3'd0, 9'd0,    9'd20};
    vt[2]  = '{1, 0, 4'd2, 3'd2, 9'h1FF,  9'd0};
    vt[3]  = '{0, 1, 4'd2, 3'd2, 9'd0,    9'd3};
    vt[4]  = '{1, 0, 4'd3, 3'd0, 9'd7,    9'd0};
    vt[5]  = '{0, 1, 4'd3, 3'd0, 9'd0,    9'd0};
    vt[6]  = '{0, 1, 4'd1, 3'd0, 9'd0,    9'd20};
    vt[7]  = '{1, 0, 4'd4, 3'd5, 9'h1FE,  9'd0};
    vt[8]  = '{0, 1, 4'd4, 3'd5, 9'd0,    9'd0};
    vt[9]  = '{1, 0, 4'd0, 3'd0, 9'h1AB,  9'd0};
    vt[10] = '{0, 1, 4'd0, 3'd0, 9'd0,    9'h1AB};
    vt[11] = '{0, 1, 4'd4, 3'd0, 9'd0,    9'd5};
    vt[12] = '{1, 1, 4'd2, 3'd1, 9'h0FF,  9'd0};
    vt[13] = '{0, 1, 4'd2, 3'd1, 9'd0,    9'd63};
    model_reset();
    dout_model = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_data_out", data_out, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_scanclk", scanclk, 0);
    check("rst_scanclkena", scanclkena, 0);
    check("rst_scandata", scandata, 0);
    check("rst_configupdate", configupdate, 0);
    nRST = 1'b1;
    @(negedge clk);

    run_scan(3, 0, 0);
    scan_checks("scan_reset_bank", 0);

    foreach (vt[i])
      do_op(vt[i].wr, vt[i].rd, vt[i].t, vt[i].p, vt[i].d, vt[i].exp, $sformatf("vec%0d", i));

    run_scan(0, 0, 0);
    scan_checks("scan_timeout", 1);
    do_op(1, 0, 4'd4, 3'd2, 9'd2, 9'd0, "post_to_write");
    check("timeout_sticky", timeout_err, 1);
    run_scan(5, 0, 0);
    scan_checks("scan_clear_te", 0);

    run_scan(2, 1, 0);
    scan_checks("scan_wr_same_cycle", 0);
    run_scan(4, 0, 1);
    scan_checks("scan_wr_during_shift", 0);

    strobe(0, 0, 1, 4'd0, 3'd0, 9'd0);
    r = 0; pc = 0;
    for (int k = 0; k < 2000 && r < 25; k++) begin
      if (scanclk && !pc) r++;
      pc = scanclk;
      if (r < 25) @(negedge clk);
    end
    check("mid_rises", r, 25);
    check("mid_scanclkena", scanclkena, 1);
    nRST = 1'b0;
    #1;
    check("mid_rst_outputs", {busy, data_out, timeout_err, scanclk, scanclkena, scandata, configupdate}, 0);
    @(negedge clk);
    nRST = 1'b1;
    model_reset();
    dout_model = '0;
    @(negedge clk);
    do_op(0, 1, 4'd1, 3'd0, 9'd0, 9'd12, "mid_read_m");
    run_scan(2, 0, 0);
    scan_checks("scan_after_mid_rst", 0);

    for (int round = 0; round < 3; round++) begin
      for (int k = 0; k < 25; k++) begin
        logic [3:0] t;
        logic [2:0] p;
        bit wr, rd;
        t = 4'($urandom_range(0, 5));
        p = 3'($urandom_range(0, 7));
        wr = 1'($urandom_range(0, 1));
        rd = 1'($urandom_range(0, 1));
        do_op(wr, rd, t, p, 9'($urandom_range(0, 511)), 9'(model_read(int'(t), int'(p))),
              $sformatf("rnd%0d_%0d", round, k));
      end
      run_scan(int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      scan_checks($sformatf("rnd%0d_scan", round), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
